seq101_detector: RTL and testbench
==================================

# seq101_detector

Registered one-hot sequence detector: holds the 4-bit one-hot state vector, applies the A/B/C/D transition table on each accepted serial bit, and produces a Moore match flag when "101" has been received (overlapping matches allowed). It wraps the combinational next-state stage with its state register, input qualification, match counting and one-hot integrity checking. Downstream logic consumes `match`, `match_pulse` and `match_cnt`.

## Interface
- `CNT_W`, 8, width of the saturating match counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in` is accepted on this clock edge when high.
- `in`  in  1  serial data bit.
- `clr_cnt`  in  1  synchronous clear of `match_cnt`.
- `state`  out  4  registered one-hot state; bit0=A, bit1=B, bit2=C, bit3=D.
- `match`  out  1  Moore output, equal to `state[3]`.
- `match_pulse`  out  1  one-cycle pulse on the cycle `state` enters D.
- `match_cnt`  out  CNT_W  saturating count of entries into D.
- `err`  out  1  sticky flag: `state` was found not one-hot.

## Operation
- Transitions apply only on edges with `in_valid`=1; with `in_valid`=0, `state` holds.
- A: in=0→A, in=1→B.
- B: in=0→C, in=1→B.
- C: in=0→A, in=1→D.
- D: in=0→C, in=1→B.
- Equivalent one-hot equations: nA = A&~in | C&~in; nB = in&(A|B|D); nC = ~in&(B|D); nD = C&in.
- `match` = `state[3]`. This is combinational from the register and has no extra latency.
- `match_pulse` is registered. It is 1 for exactly the cycle after an edge where `state` moved from non-D to D. D→D is impossible, so every entry produces one pulse.
- `match_cnt` increments by 1 on each edge where `state` enters D.
  - Saturates at 2^CNT_W−1 and does not wrap.
- `clr_cnt`=1 sets `match_cnt` to 0 on that edge.
  - It has priority over a simultaneous increment, so the result is 0 and the entry is not counted.
  - It does not affect `state`, `match_pulse` or `err`.
- Integrity check: each cycle, if `state` is not exactly one-hot (popcount≠1):
  - on the next edge, `state` is forced to A (0001) regardless of `in_valid`;
  - `err` is set to 1 and stays set until reset;
  - no count or pulse is generated for that recovery edge.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) gives `state`=0001, `match`=0, `match_pulse`=0, `match_cnt`=0, `err`=0.
- Reset asserted mid-sequence discards partial progress immediately, without waiting for a clock edge.
- Latency: the third bit of "101" is accepted at edge N. `state`=1000 and `match`=1 from edge N; `match_pulse`=1 from edge N until edge N+1. `match_cnt` updates at edge N.
- Gaps in `in_valid` are transparent: a "101" spread over non-consecutive valid cycles still matches.
- The state register is the only storage for the FSM; no bypass path from `in` to `match`.

## Test plan
- Reset, then valid bits 1,0,1 → `state` goes 0010, 0100, 1000; `match`=1; one `match_pulse`; `match_cnt`=1; `err`=0.
- Valid bits 1,0,1,0,1 → two `match_pulse`s, two cycles apart; `match_cnt`=2; final `state`=1000.
- Bits 1,0 then `in_valid`=0 for 5 cycles with `in` toggling, then valid 1 → `state` holds 0100 during the gap; then 1000; `match_cnt`=1.
- `CNT_W`=2, six "101" matches → `match_cnt` reads 1, 2, 3, 3, 3, 3.
- `clr_cnt`=1 on the same edge the state enters D → `match_cnt`=0; `match`=1 and `match_pulse`=1 still occur.
- Force `state`=0110 for one cycle → next edge `state`=0001 and `err`=1; `err` stays 1 through further matches; `rst_n` low clears all outputs to their reset values.

Source files
------------

// File: rtl/seq101_detector.sv
// One-hot "101" detector with valid-qualified input, saturating match counter and sticky one-hot check.
// match is combinational from the state register; match_pulse/match_cnt update on the entering edge; no backpressure.
module seq101_detector #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in,
   input  logic             clr_cnt,
   output logic [3:0]       state,
   output logic             match,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_cnt,
   output logic             err
);

   typedef enum logic [3:0] {
      ST_A = 4'b0001,
      ST_B = 4'b0010,
      ST_C = 4'b0100,
      ST_D = 4'b1000
   } st_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [3:0]       state_r;
   logic [3:0]       state_n;
   logic             onehot;
   logic             enter_d;
   logic [CNT_W-1:0] cnt_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_A;
         match_pulse <= 1'b0;
         match_cnt   <= '0;
         err         <= 1'b0;
      end else begin
         state_r     <= state_n;
         match_pulse <= enter_d;
         match_cnt   <= cnt_n;
         err         <= err | ~onehot;
      end
   end

   always_comb begin
      state_n = state_r;
      enter_d = 1'b0;
      cnt_n   = match_cnt;
      onehot  = $onehot(state_r);

      // A corrupted state recovers to A unconditionally and is never counted.
      if (!onehot) begin
         state_n = ST_A;
      end else if (in_valid) begin
         case (state_r)
            ST_A:    state_n = in ? ST_B : ST_A;
            ST_B:    state_n = in ? ST_B : ST_C;
            ST_C:    state_n = in ? ST_D : ST_A;
            ST_D:    state_n = in ? ST_B : ST_C;
            default: state_n = ST_A;
         endcase
         enter_d = (state_r == ST_C) && in;
      end

      if (clr_cnt) begin
         cnt_n = '0;
      end else if (enter_d && (match_cnt != CNT_MAX)) begin
         cnt_n = match_cnt + 1'b1;
      end
   end

   assign state = state_r;
   assign match = state_r[3];

endmodule

// File: tb/tb_seq101_detector.sv
// Scoreboard bench for seq101_detector: an 8-bit and a 2-bit counter instance share all stimulus.
module tb_seq101_detector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in = 1'b0;
   logic       clr_cnt = 1'b0;
   logic [3:0] state, state2;
   logic       match, match2, match_pulse, match_pulse2, err, err2;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt2;

   always #5 clk = ~clk;

   seq101_detector #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .clr_cnt(clr_cnt),
      .state(state), .match(match), .match_pulse(match_pulse), .match_cnt(match_cnt), .err(err)
   );

   seq101_detector #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .clr_cnt(clr_cnt),
      .state(state2), .match(match2), .match_pulse(match_pulse2), .match_cnt(match_cnt2), .err(err2)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       mt;
      logic       pl;
      logic [7:0] cnt;
      logic [1:0] cnt2;
      logic       er;
   } exp_t;

   exp_t       sb[$];
   int         n_pass = 0;
   int         n_total = 0;

   logic [3:0] m_state;
   logic       m_pulse;
   logic [7:0] m_cnt;
   logic [1:0] m_cnt2;
   logic       m_err;

   task automatic model_reset();
      m_state = 4'b0001; m_pulse = 1'b0; m_cnt = '0; m_cnt2 = '0; m_err = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; in = 1'b0; clr_cnt = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Drive one cycle, advance the reference model, then pop and compare after the edge.
   task automatic step(input logic v, input logic b, input logic c);
      exp_t e;
      logic [3:0] nx;
      logic a_, b_, c_, d_, entered;
      @(negedge clk);
      in_valid = v; in = b; clr_cnt = c;
      @(posedge clk);
      {d_, c_, b_, a_} = m_state;
      entered = 1'b0;
      if ((a_ + b_ + c_ + d_) != 1) begin
         nx = 4'b0001;
         m_err = 1'b1;
      end else if (v) begin
         nx = {c_ & b, ~b & (b_ | d_), b & (a_ | b_ | d_), (a_ & ~b) | (c_ & ~b)};
         entered = nx[3];
      end else begin
         nx = m_state;
      end
      m_state = nx;
      m_pulse = entered;
      if (c) begin
         m_cnt = '0; m_cnt2 = '0;
      end else if (entered) begin
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 1'b1;
         if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 1'b1;
      end
      sb.push_back('{st: m_state, mt: m_state[3], pl: m_pulse, cnt: m_cnt, cnt2: m_cnt2, er: m_err});
      #1;
      e = sb.pop_front();
      n_total += 6;
      if (state !== e.st) $display("FAIL sb_state got %b want %b", state, e.st); else n_pass++;
      if (match !== e.mt) $display("FAIL sb_match got %b want %b", match, e.mt); else n_pass++;
      if (match_pulse !== e.pl) $display("FAIL sb_pulse got %b want %b", match_pulse, e.pl); else n_pass++;
      if (match_cnt !== e.cnt) $display("FAIL sb_cnt got %0d want %0d", match_cnt, e.cnt); else n_pass++;
      if (match_cnt2 !== e.cnt2) $display("FAIL sb_cnt2 got %0d want %0d", match_cnt2, e.cnt2); else n_pass++;
      if (err !== e.er) $display("FAIL sb_err got %b want %b", err, e.er); else n_pass++;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_total++;
      if ({state, match, match_pulse, match_cnt, err} !== {4'b0001, 1'b0, 1'b0, 8'd0, 1'b0}) begin
         $display("FAIL reset_outputs got st=%b m=%b p=%b c=%0d e=%b want st=0001 m=0 p=0 c=0 e=0",
                  state, match, match_pulse, match_cnt, err);
      end else n_pass++;
   endtask

   task automatic test_basic();
      logic [3:0] want [3];
      logic [1:0] bits;
      want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b1000;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bits = (i == 1) ? 2'b00 : 2'b01;
         step(1'b1, bits[0], 1'b0);
         n_total++;
         if (state !== want[i]) $display("FAIL basic_state[%0d] got %b want %b", i, state, want[i]);
         else n_pass++;
      end
      n_total++;
      if (match !== 1'b1 || match_pulse !== 1'b1 || match_cnt !== 8'd1)
         $display("FAIL basic_match got m=%b p=%b c=%0d want m=1 p=1 c=1", match, match_pulse, match_cnt);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0);
      n_total++;
      if (match_pulse !== 1'b0) $display("FAIL basic_pulse_width got %b want 0", match_pulse);
      else n_pass++;
   endtask

   task automatic test_overlap();
      int pulse_at [$];
      logic [4:0] seq;
      seq = 5'b10101;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, seq[4-i], 1'b0);
         if (match_pulse === 1'b1) pulse_at.push_back(i);
      end
      n_total++;
      if (pulse_at.size() != 2 || pulse_at[0] != 2 || pulse_at[1] != 4)
         $display("FAIL overlap_pulses got %0d pulses want 2 at cycles 2,4", pulse_at.size());
      else n_pass++;
      n_total++;
      if (match_cnt !== 8'd2 || state !== 4'b1000)
         $display("FAIL overlap_final got c=%0d st=%b want c=2 st=1000", match_cnt, state);
      else n_pass++;
   endtask

   task automatic test_gap();
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, i[0], 1'b0);
         n_total++;
         if (state !== 4'b0100) $display("FAIL gap_hold[%0d] got %b want 0100", i, state);
         else n_pass++;
      end
      step(1'b1, 1'b1, 1'b0);
      n_total++;
      if (state !== 4'b1000 || match_cnt !== 8'd1)
         $display("FAIL gap_match got st=%b c=%0d want st=1000 c=1", state, match_cnt);
      else n_pass++;
   endtask

   task automatic test_saturate();
      logic [1:0] want [6];
      want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3; want[5] = 2'd3;
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0);
         n_total++;
         if (match_cnt2 !== want[k]) $display("FAIL sat_cnt2[%0d] got %0d want %0d", k, match_cnt2, want[k]);
         else n_pass++;
      end
   endtask

   task automatic test_clr();
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_total++;
      if (match_cnt !== 8'd0 || match !== 1'b1 || match_pulse !== 1'b1)
         $display("FAIL clr_on_entry got c=%0d m=%b p=%b want c=0 m=1 p=1", match_cnt, match, match_pulse);
      else n_pass++;
   endtask

   task automatic test_integrity();
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      force dut.state_r = 4'b0110;
      force dut2.state_r = 4'b0110;
      #1;
      release dut.state_r;
      release dut2.state_r;
      m_state = 4'b0110;
      step(1'b1, 1'b1, 1'b0);
      n_total++;
      if (state !== 4'b0001 || err !== 1'b1 || match_pulse !== 1'b0)
         $display("FAIL integ_recover got st=%b e=%b p=%b want st=0001 e=1 p=0", state, err, match_pulse);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0);
         n_total++;
         if (err !== 1'b1 || match !== 1'b1) $display("FAIL integ_sticky[%0d] got e=%b m=%b want e=1 m=1", k, err, match);
         else n_pass++;
      end
      step(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({state, match, match_pulse, match_cnt, err} !== {4'b0001, 1'b0, 1'b0, 8'd0, 1'b0}) begin
         $display("FAIL async_reset got st=%b m=%b p=%b c=%0d e=%b want st=0001 m=0 p=0 c=0 e=0",
                  state, match, match_pulse, match_cnt, err);
      end else n_pass++;
      n_total++;
      if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size());
      else n_pass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_overlap();
      test_gap();
      test_saturate();
      test_clr();
      test_integrity();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
